// File: rtl/vga_timing_engine.sv
`default_nettype none
// =============================================================================
// vga_timing_engine : parametrised VGA H/V timing with a one-stage pixel output
//                     pipeline; VGA_TEST_PATTERN_EN adds test_mode colour bars.
// Revision          : 1.0
// =============================================================================
module vga_timing_engine #(
  parameter int   H_ACTIVE  = 640,
  parameter int   H_FP      = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BP      = 48,
  parameter int   V_ACTIVE  = 480,
  parameter int   V_FP      = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BP      = 33,
  parameter int   COLOR_W   = 1,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0,
  localparam int  H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int  V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int  CW        = $clog2(H_TOTAL),
  localparam int  RW        = $clog2(V_TOTAL)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pix_en,
  output logic [CW-1:0]      col,
  output logic [RW-1:0]      row,
  output logic               req_active,
  input  logic [COLOR_W-1:0] r_in,
  input  logic [COLOR_W-1:0] g_in,
  input  logic [COLOR_W-1:0] b_in,
`ifdef VGA_TEST_PATTERN_EN
  input  logic               test_mode,
`endif
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [COLOR_W-1:0] r_out,
  output logic [COLOR_W-1:0] g_out,
  output logic [COLOR_W-1:0] b_out,
  output logic               frame_start
);

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [RW-1:0] V_LAST = RW'(V_TOTAL - 1);

  logic [CW-1:0]      col_q, col_d;
  logic [RW-1:0]      row_q, row_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               de_q, de_d;
  logic [COLOR_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic               fs_q, fs_d;

  logic               h_win, v_win;
  logic [COLOR_W-1:0] pix_r, pix_g, pix_b;

  // Stage 0: free-running raster counters
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (pix_en) begin
      if (col_q == H_LAST) begin
        col_d = '0;
        row_d = (row_q == V_LAST) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  assign req_active = (int'(col_q) < H_ACTIVE) && (int'(row_q) < V_ACTIVE);
  assign h_win = (int'(col_q) >= H_ACTIVE + H_FP) && (int'(col_q) < H_ACTIVE + H_FP + H_SYNC);
  assign v_win = (int'(row_q) >= V_ACTIVE + V_FP) && (int'(row_q) < V_ACTIVE + V_FP + V_SYNC);

`ifdef VGA_TEST_PATTERN_EN
  logic [31:0] bar;
  assign bar = 32'(int'(col_q) / (H_ACTIVE / 8));
  assign pix_r = test_mode ? {COLOR_W{bar[2]}} : r_in;
  assign pix_g = test_mode ? {COLOR_W{bar[1]}} : g_in;
  assign pix_b = test_mode ? {COLOR_W{bar[0]}} : b_in;
`else
  assign pix_r = r_in;
  assign pix_g = g_in;
  assign pix_b = b_in;
`endif

  // Stage 1 samples the pre-increment counters so outputs trail them by one strobe
  always_comb begin
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    de_d    = de_q;
    r_d     = r_q;
    g_d     = g_q;
    b_d     = b_q;
    fs_d    = 1'b0;
    if (pix_en) begin
      de_d    = req_active;
      hsync_d = h_win ? HSYNC_POL : ~HSYNC_POL;
      vsync_d = v_win ? VSYNC_POL : ~VSYNC_POL;
      r_d     = req_active ? pix_r : '0;
      g_d     = req_active ? pix_g : '0;
      b_d     = req_active ? pix_b : '0;
      fs_d    = (col_q == '0) && (row_q == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      col_q   <= '0;
      row_q   <= '0;
      hsync_q <= ~HSYNC_POL;
      vsync_q <= ~VSYNC_POL;
      de_q    <= 1'b0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      fs_q    <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
      fs_q    <= fs_d;
    end
  end

  assign col         = col_q;
  assign row         = row_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign r_out       = r_q;
  assign g_out       = g_q;
  assign b_out       = b_q;
  assign frame_start = fs_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_engine.sv
`default_nettype none
// =============================================================================
// tb_vga_timing_engine : bench for vga_timing_engine on a reduced raster, with
//                        a raster-arithmetic reference model.
// Revision             : 1.0
// =============================================================================
module tb_vga_timing_engine;

  localparam int   HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int   VA = 6,  VF = 1, VS = 2, VB = 1;
  localparam int   CWID = 4;
  localparam logic HP = 1'b0;
  localparam logic VP = 1'b1;
  localparam int   HT = HA + HF + HS + HB;
  localparam int   VT = VA + VF + VS + VB;
  localparam int   FRAME = HT * VT;
  localparam int   CW = $clog2(HT);
  localparam int   RW = $clog2(VT);

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            pix_en = 1'b0;
  logic [CWID-1:0] r_in = '0, g_in = '0, b_in = '0;
  logic            test_mode = 1'b0;
  logic [CW-1:0]   col;
  logic [RW-1:0]   row;
  logic            req_active, hsync, vsync, de, frame_start;
  logic [CWID-1:0] r_out, g_out, b_out;

  vga_timing_engine #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .COLOR_W(CWID), .HSYNC_POL(HP), .VSYNC_POL(VP)
  ) dut (
    .clk(clk), .reset(reset), .pix_en(pix_en),
    .col(col), .row(row), .req_active(req_active),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
`ifdef VGA_TEST_PATTERN_EN
    .test_mode(test_mode),
`endif
    .hsync(hsync), .vsync(vsync), .de(de),
    .r_out(r_out), .g_out(g_out), .b_out(b_out),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

`ifdef VGA_TEST_PATTERN_EN
  localparam bit TP_ON = 1'b1;
`else
  localparam bit TP_ON = 1'b0;
`endif

  int n_chk = 0, n_pass = 0, cyc = 0;
  int n = 0;                         // strobes since last reset
  bit tm_force = 1'b0;
  logic            e_hs, e_vs, e_de, e_fs;
  logic [CWID-1:0] e_r, e_g, e_b;
  int fs_cyc[$];
  int de_frames[$];
  int vs_frames[$];
  int de_acc = 0, vs_acc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
  endtask

  // Reference: the outputs show the pixel addressed by the strobe just taken.
  task automatic model_update();
    int p, c, r, bar;
    if (!reset) begin
      n = 0;
      e_hs = ~HP; e_vs = ~VP; e_de = 1'b0; e_fs = 1'b0;
      e_r = '0; e_g = '0; e_b = '0;
    end else if (pix_en) begin
      p = n % FRAME;
      c = p % HT;
      r = p / HT;
      e_de = (c < HA) && (r < VA);
      e_hs = (c >= HA + HF && c < HA + HF + HS) ? HP : ~HP;
      e_vs = (r >= VA + VF && r < VA + VF + VS) ? VP : ~VP;
      if (!e_de) begin
        e_r = '0; e_g = '0; e_b = '0;
      end else if (TP_ON && test_mode) begin
        bar = c / (HA / 8);
        e_r = bar[2] ? '1 : '0;
        e_g = bar[1] ? '1 : '0;
        e_b = bar[0] ? '1 : '0;
      end else begin
        e_r = r_in; e_g = g_in; e_b = b_in;
      end
      e_fs = (p == 0);
      n++;
    end else begin
      e_fs = 1'b0;
    end
  endtask

  task automatic check_all();
    int p, c, r;
    p = n % FRAME;
    c = p % HT;
    r = p / HT;
    chk("col", 32'(col), c);
    chk("row", 32'(row), r);
    chk("req_active", 32'(req_active), 32'((c < HA) && (r < VA)));
    chk("hsync", 32'(hsync), 32'(e_hs));
    chk("vsync", 32'(vsync), 32'(e_vs));
    chk("de", 32'(de), 32'(e_de));
    chk("rgb", {20'd0, r_out, g_out, b_out}, {20'd0, e_r, e_g, e_b});
    chk("frame_start", 32'(frame_start), 32'(e_fs));
    if (frame_start === 1'b1) begin
      fs_cyc.push_back(cyc);
      de_frames.push_back(de_acc);
      vs_frames.push_back(vs_acc);
      de_acc = 0;
      vs_acc = 0;
    end
    de_acc += (de === 1'b1) ? 1 : 0;
    vs_acc += (vsync === VP) ? 1 : 0;
  endtask

  task automatic tick(input bit en);
    pix_en    = en;
    r_in      = CWID'($urandom);
    g_in      = CWID'($urandom);
    b_in      = CWID'($urandom);
    test_mode = tm_force | 1'($urandom_range(0, 1));
    @(posedge clk);
    model_update();
    @(negedge clk);
    cyc++;
    check_all();
  endtask

  task automatic clear_stats();
    fs_cyc.delete();
    de_frames.delete();
    vs_frames.delete();
    de_acc = 0;
    vs_acc = 0;
  endtask

  initial begin
    // Reset with pix_en high
    reset = 1'b0;
    for (int i = 0; i < 3; i++) tick(1'b1);
    reset = 1'b1;

    // Continuous strobes over two full frames
    clear_stats();
    for (int i = 0; i < 2 * FRAME + 2; i++) tick(1'b1);
    chk("fs_count_cont", fs_cyc.size(), 3);
    if (fs_cyc.size() >= 3) begin
      chk("fs_period_cont", fs_cyc[2] - fs_cyc[1], FRAME);
      chk("de_per_frame", de_frames[2], HA * VA);
      chk("vs_per_frame", vs_frames[2], VS * HT);
    end

    // One strobe every fourth clock
    clear_stats();
    for (int i = 0; i < 8 * FRAME + 8; i++) tick(i % 4 == 0);
    chk("fs_count_slow", fs_cyc.size() >= 2, 1);
    if (fs_cyc.size() >= 2) chk("fs_period_slow", fs_cyc[1] - fs_cyc[0], 4 * FRAME);

    // Mid-frame reset at col 20, row 3
    for (int i = 0; i < FRAME && (n % FRAME) != 3 * HT + 20; i++) tick(1'b1);
    chk("reached_reset_point", n % FRAME, 3 * HT + 20);
    reset = 1'b0;
    tick(1'b1);
    reset = 1'b1;
    clear_stats();
    for (int i = 0; i < FRAME + 2; i++) tick(1'b1);
    chk("fs_count_after_reset", fs_cyc.size(), 2);
    if (fs_cyc.size() >= 2) chk("fs_period_after_reset", fs_cyc[1] - fs_cyc[0], FRAME);

    // Random stalls and occasional resets
    for (int i = 0; i < 3 * FRAME; i++) begin
      reset = ($urandom_range(0, 99) != 0);
      tick(1'($urandom_range(0, 1)));
    end
    reset = 1'b1;

    // Forced colour bars across a whole frame
    tm_force = 1'b1;
    for (int i = 0; i < FRAME; i++) tick(1'b1);
    tm_force = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
